fp_add_sub: RTL and testbench

//  Multi-cycle IEEE-754 single-precision adder/subtractor. Consumes products from
//  the FP multiplier in the expanded hyperbolic CORDIC exponential datapath and

---
 rtl/fp_add_sub.sv | 181 ++++++++++++++++++
 tb/tb_fp_add_sub.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fp_add_sub.sv
// Multi-cycle single-precision FP adder/subtractor: IDLE -> ALIGN -> ADD -> NORM, done after 4 edges.
// Build option: define FP_ADD_ROUND_EN for round-to-nearest-even, otherwise results are truncated.
module fp_add_sub #(
  parameter int unsigned P    = 32,
  parameter logic [7:0]  BIAS = 8'd127
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [P-1:0] a,
  input  logic [P-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [P-1:0] result,
  output logic         ovf,
  output logic         unf
);

  typedef enum logic [1:0] {StIdle, StAlign, StAdd, StNorm} state_e;

  // Largest biased exponent (all ones) marks overflow.
  localparam logic signed [9:0] ExpMax = $signed({1'b0, BIAS, 1'b1});

  state_e         state_q, state_d;
  logic [P-1:0]   a_q, b_q;
  logic           eff_op_q;
  logic           sign_q;
  logic [7:0]     exp_q;
  logic [26:0]    mant_l_q, mant_s_q;
  logic [27:0]    sum_q;
  logic [P-1:0]   result_q;
  logic           ovf_q, unf_q, done_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAlign;
      StAlign: state_d = StAdd;
      StAdd:   state_d = StNorm;
      StNorm:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Alignment: pick larger magnitude, shift the smaller right keeping a sticky bit.
  logic [7:0]  ea, eb, el, es, de;
  logic [30:0] key_a, key_b;
  logic [26:0] ma, mb, ml, ms, s_al, low_mask;
  logic        a_big, l_sign;

  always_comb begin
    ea       = a_q[30:23];
    eb       = b_q[30:23];
    ma       = (ea == 8'd0) ? 27'd0 : {1'b1, a_q[22:0], 3'b000};
    mb       = (eb == 8'd0) ? 27'd0 : {1'b1, b_q[22:0], 3'b000};
    key_a    = (ea == 8'd0) ? 31'd0 : a_q[30:0];
    key_b    = (eb == 8'd0) ? 31'd0 : b_q[30:0];
    a_big    = key_a >= key_b;
    el       = a_big ? ea : eb;
    es       = a_big ? eb : ea;
    ml       = a_big ? ma : mb;
    ms       = a_big ? mb : ma;
    l_sign   = a_big ? a_q[31] : b_q[31];
    de       = el - es;
    low_mask = ~({27{1'b1}} << de);
    if (de >= 8'd27) s_al = {26'd0, |ms};
    else             s_al = (ms >> de) | {26'd0, |(ms & low_mask)};
  end

  // Normalisation, rounding and exception handling.
  logic [4:0]        lz;
  logic [26:0]       nm;
  logic signed [9:0] ne;
  logic [24:0]       m24;
  logic              inc;
  logic [22:0]       frac;
  logic [P-1:0]      res_d;
  logic              ovf_d, unf_d;
`ifndef FP_ADD_ROUND_EN
  logic              unused_grs;
`endif

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum_q[i]) lz = 5'(26 - i);
    end
    if (sum_q[27]) begin
      nm = {sum_q[27:2], |sum_q[1:0]};
      ne = $signed({2'b00, exp_q}) + 10'sd1;
    end else begin
      nm = sum_q[26:0] << lz;
      ne = $signed({2'b00, exp_q}) - $signed({5'd0, lz});
    end
`ifdef FP_ADD_ROUND_EN
    inc = nm[2] & (nm[1] | nm[0] | nm[3]);
`else
    inc        = 1'b0;
    unused_grs = ^nm[2:0];
`endif
    m24 = {1'b0, nm[26:3]} + {24'd0, inc};
    if (m24[24]) begin
      frac = m24[23:1];
      ne   = ne + 10'sd1;
    end else begin
      frac = m24[22:0];
    end
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (sum_q == 28'd0) begin
      res_d = '0;
    end else if (ne >= ExpMax) begin
      ovf_d = 1'b1;
      res_d = {sign_q, 8'hFF, 23'd0};
    end else if (ne <= 10'sd0) begin
      unf_d = 1'b1;
    end else begin
      res_d = {sign_q, ne[7:0], frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      eff_op_q <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_l_q <= '0;
      mant_s_q <= '0;
      sum_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q      <= a;
            // Subtraction is folded into b's sign here.
            b_q      <= {b[31] ^ op, b[30:0]};
            eff_op_q <= a[31] ^ b[31] ^ op;
          end
        end
        StAlign: begin
          sign_q   <= l_sign;
          exp_q    <= el;
          mant_l_q <= ml;
          mant_s_q <= s_al;
        end
        StAdd: begin
          sum_q <= eff_op_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                            : ({1'b0, mant_l_q} + {1'b0, mant_s_q});
        end
        StNorm: begin
          result_q <= res_d;
          ovf_q    <= ovf_d;
          unf_q    <= unf_d;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule

// File: tb/tb_fp_add_sub.sv
// Directed bench for fp_add_sub: arithmetic, rounding, exceptions, handshake and reset abort.
module tb_fp_add_sub;

  logic        clk = 1'b0;
  logic        rst_n, start, op;
  logic [31:0] a, b, result;
  logic        busy, done, ovf, unf;
  int          tests = 0;
  int          fails = 0;
  int          n;

  fp_add_sub dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .unf    (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that sampled start.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic top);
    a = ta;
    b = tb_v;
    op = top;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!done && cnt < 10);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                        input logic [31:0] er, input logic eo, input logic eu,
                        input string tag);
    int cnt;
    issue(ta, tb_v, top);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(cnt);
    check({tag, "_latency"}, 32'(cnt), 32'd3);
    check({tag, "_result"}, result, er);
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check({tag, "_unf"}, 32'(unf), 32'(eu));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_unf", 32'(unf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, "add_1_2");
    run_op(32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 1'b0, 1'b0, "sub_equal");
    run_op(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 1'b0, 1'b0, "cancel_lzc24");
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, "overflow");
    run_op(32'h40000000, 32'hBF800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, "ovf_clear");
    run_op(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, "sub_neg");
`ifdef FP_ADD_ROUND_EN
    run_op(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0, "round_up");
`else
    run_op(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 1'b0, 1'b0, "round_trunc");
`endif
    run_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, "round_tie");
    run_op(32'h00000000, 32'hC0000000, 1'b1, 32'h40000000, 1'b0, 1'b0, "zero_a_sub");
    run_op(32'h41200000, 32'h00000000, 1'b0, 32'h41200000, 1'b0, 1'b0, "zero_b");
    run_op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0, "both_zero");
    run_op(32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, "underflow");

    // start pulses during ALIGN and ADD must be ignored
    issue(32'h3F800000, 32'h40000000, 1'b0);
    a = 32'h41200000;
    b = 32'h41200000;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("ign_busy_add", 32'(busy), 32'd1);
    a = 32'h7F7FFFFF;
    b = 32'h7F7FFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_done_early", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("ign_done", 32'(done), 32'd1);
    check("ign_result", result, 32'h40400000);

    // start in the done cycle is accepted
    issue(32'h40000000, 32'hBF800000, 1'b0);
    check("b2b_done_pulse", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("b2b_latency", 32'(n), 32'd3);
    check("b2b_result", result, 32'h3F800000);

    // reset during ADD aborts the operation
    issue(32'h41200000, 32'h3F800000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    #2;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check("abort_no_done", 32'(n), 32'd0);
    run_op(32'h41200000, 32'h3F800000, 1'b0, 32'h41300000, 1'b0, 1'b0, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
